// File: rtl/axi_lite_master_interface.sv
// AXI4-Lite single-outstanding master.
// A user command strobe in IDLE launches one write (AW+W, then B) or one read (AR, then R).
// Completion is signalled by a one-cycle o_done pulse; the last response and read data are held.
module axi_lite_master_interface #(
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned TRANS_W_STRB_W  = 4,
  parameter int unsigned TRANS_WR_RESP_W = 2,
  parameter int unsigned TRANS_PROT      = 3
) (
  input  logic                       clk_i,
  input  logic                       resetn_i,
  // User command side
  input  logic                       i_req,
  input  logic                       i_we,
  input  logic [ADDR_WIDTH-1:0]      i_addr,
  input  logic [DATA_WIDTH-1:0]      i_wdata,
  input  logic [TRANS_W_STRB_W-1:0]  i_wstrb,
  input  logic [TRANS_PROT-1:0]      i_prot,
  output logic                       o_busy,
  output logic                       o_done,
  output logic [DATA_WIDTH-1:0]      o_rdata,
  output logic [TRANS_WR_RESP_W-1:0] o_resp,
  // Write address channel
  output logic [ADDR_WIDTH-1:0]      o_axi_awaddr,
  output logic [TRANS_PROT-1:0]      o_axi_awprot,
  output logic                       o_axi_awvalid,
  input  logic                       i_axi_awready,
  // Write data channel
  output logic [DATA_WIDTH-1:0]      o_axi_wdata,
  output logic [TRANS_W_STRB_W-1:0]  o_axi_wstrb,
  output logic                       o_axi_wvalid,
  input  logic                       i_axi_wready,
  // Write response channel
  input  logic [TRANS_WR_RESP_W-1:0] i_axi_bresp,
  input  logic                       i_axi_bvalid,
  output logic                       o_axi_bready,
  // Read address channel
  output logic [ADDR_WIDTH-1:0]      o_axi_araddr,
  output logic [TRANS_PROT-1:0]      o_axi_arprot,
  output logic                       o_axi_arvalid,
  input  logic                       i_axi_arready,
  // Read data channel
  input  logic [DATA_WIDTH-1:0]      i_axi_rdata,
  input  logic [TRANS_WR_RESP_W-1:0] i_axi_rresp,
  input  logic                       i_axi_rvalid,
  output logic                       o_axi_rready
);

  typedef enum logic [2:0] {
    StIdle,
    StWrAwW,
    StWrB,
    StRdAr,
    StRdR
  } state_e;

  state_e                     state_q;

  // Captured command payload; drives both AW/W and AR channels.
  logic [ADDR_WIDTH-1:0]      addr_q;
  logic [DATA_WIDTH-1:0]      wdata_q;
  logic [TRANS_W_STRB_W-1:0]  wstrb_q;
  logic [TRANS_PROT-1:0]      prot_q;

  // Registered handshake controls, so no AXI input reaches a valid/ready output combinationally.
  logic                       awvalid_q;
  logic                       wvalid_q;
  logic                       bready_q;
  logic                       arvalid_q;
  logic                       rready_q;

  logic                       done_q;
  logic [DATA_WIDTH-1:0]      rdata_q;
  logic [TRANS_WR_RESP_W-1:0] resp_q;

  logic                       aw_hs;
  logic                       w_hs;
  logic                       aw_done;
  logic                       w_done;

  // Write-channel handshake status; a channel counts as done once its valid has already dropped.
  always_comb begin
    aw_hs   = awvalid_q & i_axi_awready;
    w_hs    = wvalid_q & i_axi_wready;
    aw_done = ~awvalid_q | aw_hs;
    w_done  = ~wvalid_q | w_hs;
  end

  // Transaction FSM with all outputs registered alongside the state.
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      prot_q    <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      done_q    <= 1'b0;
      rdata_q   <= '0;
      resp_q    <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (i_req) begin
            addr_q  <= i_addr;
            wdata_q <= i_wdata;
            wstrb_q <= i_wstrb;
            prot_q  <= i_prot;
            if (i_we) begin
              state_q   <= StWrAwW;
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
            end else begin
              state_q   <= StRdAr;
              arvalid_q <= 1'b1;
            end
          end
        end
        StWrAwW: begin
          // AW and W complete independently; B is only opened once both have.
          if (aw_hs) begin
            awvalid_q <= 1'b0;
          end
          if (w_hs) begin
            wvalid_q <= 1'b0;
          end
          if (aw_done && w_done) begin
            state_q  <= StWrB;
            bready_q <= 1'b1;
          end
        end
        StWrB: begin
          if (i_axi_bvalid) begin
            resp_q   <= i_axi_bresp;
            done_q   <= 1'b1;
            bready_q <= 1'b0;
            state_q  <= StIdle;
          end
        end
        StRdAr: begin
          if (i_axi_arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= StRdR;
          end
        end
        StRdR: begin
          if (i_axi_rvalid) begin
            rdata_q  <= i_axi_rdata;
            resp_q   <= i_axi_rresp;
            done_q   <= 1'b1;
            rready_q <= 1'b0;
            state_q  <= StIdle;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign o_busy        = (state_q != StIdle);
  assign o_done        = done_q;
  assign o_rdata       = rdata_q;
  assign o_resp        = resp_q;

  assign o_axi_awaddr  = addr_q;
  assign o_axi_awprot  = prot_q;
  assign o_axi_awvalid = awvalid_q;
  assign o_axi_wdata   = wdata_q;
  assign o_axi_wstrb   = wstrb_q;
  assign o_axi_wvalid  = wvalid_q;
  assign o_axi_bready  = bready_q;
  assign o_axi_araddr  = addr_q;
  assign o_axi_arprot  = prot_q;
  assign o_axi_arvalid = arvalid_q;
  assign o_axi_rready  = rready_q;

endmodule

// File: tb/tb_axi_lite_master_interface.sv
// Directed bench for axi_lite_master_interface with a delay-configurable AXI-Lite slave.
module tb_axi_lite_master_interface;

  logic        clk;
  logic        resetn;
  logic        i_req;
  logic        i_we;
  logic [31:0] i_addr;
  logic [31:0] i_wdata;
  logic [3:0]  i_wstrb;
  logic [2:0]  i_prot;
  logic        o_busy;
  logic        o_done;
  logic [31:0] o_rdata;
  logic [1:0]  o_resp;
  logic [31:0] o_axi_awaddr;
  logic [2:0]  o_axi_awprot;
  logic        o_axi_awvalid;
  logic        i_axi_awready;
  logic [31:0] o_axi_wdata;
  logic [3:0]  o_axi_wstrb;
  logic        o_axi_wvalid;
  logic        i_axi_wready;
  logic [1:0]  i_axi_bresp;
  logic        i_axi_bvalid;
  logic        o_axi_bready;
  logic [31:0] o_axi_araddr;
  logic [2:0]  o_axi_arprot;
  logic        o_axi_arvalid;
  logic        i_axi_arready;
  logic [31:0] i_axi_rdata;
  logic [1:0]  i_axi_rresp;
  logic        i_axi_rvalid;
  logic        o_axi_rready;

  axi_lite_master_interface #(
    .ADDR_WIDTH      (32),
    .DATA_WIDTH      (32),
    .TRANS_W_STRB_W  (4),
    .TRANS_WR_RESP_W (2),
    .TRANS_PROT      (3)
  ) u_dut (
    .clk_i         (clk),
    .resetn_i      (resetn),
    .i_req         (i_req),
    .i_we          (i_we),
    .i_addr        (i_addr),
    .i_wdata       (i_wdata),
    .i_wstrb       (i_wstrb),
    .i_prot        (i_prot),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_rdata       (o_rdata),
    .o_resp        (o_resp),
    .o_axi_awaddr  (o_axi_awaddr),
    .o_axi_awprot  (o_axi_awprot),
    .o_axi_awvalid (o_axi_awvalid),
    .i_axi_awready (i_axi_awready),
    .o_axi_wdata   (o_axi_wdata),
    .o_axi_wstrb   (o_axi_wstrb),
    .o_axi_wvalid  (o_axi_wvalid),
    .i_axi_wready  (i_axi_wready),
    .i_axi_bresp   (i_axi_bresp),
    .i_axi_bvalid  (i_axi_bvalid),
    .o_axi_bready  (o_axi_bready),
    .o_axi_araddr  (o_axi_araddr),
    .o_axi_arprot  (o_axi_arprot),
    .o_axi_arvalid (o_axi_arvalid),
    .i_axi_arready (i_axi_arready),
    .i_axi_rdata   (i_axi_rdata),
    .i_axi_rresp   (i_axi_rresp),
    .i_axi_rvalid  (i_axi_rvalid),
    .o_axi_rready  (o_axi_rready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Slave configuration (written by the main process only).
  int          aw_delay = 0;
  int          w_delay  = 0;
  int          ar_delay = 0;
  int          b_delay  = 0;
  int          r_delay  = 0;
  logic [1:0]  bresp_cfg = 2'b00;
  logic [1:0]  rresp_cfg = 2'b00;
  logic [31:0] rdata_cfg = 32'h0;

  // Monitor state (written by the slave process only).
  int          aw_hs = 0, w_hs = 0, ar_hs = 0;
  int          aw_cyc = 0, w_cyc = 0, ar_cyc = 0;
  int          done_cnt = 0, order_err = 0;
  logic [31:0] cap_awaddr = 0, cap_wdata = 0, cap_araddr = 0;
  logic [3:0]  cap_wstrb = 0;
  logic [2:0]  cap_awprot = 0, cap_arprot = 0;

  // Slave + monitor: drives ready/valid at the falling edge, records what the next rising edge sees.
  initial begin
    int aw_wait, w_wait, ar_wait, b_wait, r_wait;
    aw_wait = 0; w_wait = 0; ar_wait = 0; b_wait = 0; r_wait = 0;
    i_axi_awready = 1'b0;
    i_axi_wready  = 1'b0;
    i_axi_arready = 1'b0;
    i_axi_bvalid  = 1'b0;
    i_axi_bresp   = 2'b00;
    i_axi_rvalid  = 1'b0;
    i_axi_rresp   = 2'b00;
    i_axi_rdata   = 32'h0;
    forever begin
      @(negedge clk);
      if (o_done) done_cnt++;
      if (o_axi_bready && (o_axi_awvalid || o_axi_wvalid)) order_err++;
      if (o_axi_rready && o_axi_arvalid) order_err++;
      if (o_axi_awvalid) begin
        aw_cyc++;
        i_axi_awready = (aw_wait >= aw_delay);
        aw_wait++;
        if (i_axi_awready) begin
          aw_hs++;
          cap_awaddr = o_axi_awaddr;
          cap_awprot = o_axi_awprot;
        end
      end else begin
        i_axi_awready = 1'b0;
        aw_wait = 0;
      end
      if (o_axi_wvalid) begin
        w_cyc++;
        i_axi_wready = (w_wait >= w_delay);
        w_wait++;
        if (i_axi_wready) begin
          w_hs++;
          cap_wdata = o_axi_wdata;
          cap_wstrb = o_axi_wstrb;
        end
      end else begin
        i_axi_wready = 1'b0;
        w_wait = 0;
      end
      if (o_axi_arvalid) begin
        ar_cyc++;
        i_axi_arready = (ar_wait >= ar_delay);
        ar_wait++;
        if (i_axi_arready) begin
          ar_hs++;
          cap_araddr = o_axi_araddr;
          cap_arprot = o_axi_arprot;
        end
      end else begin
        i_axi_arready = 1'b0;
        ar_wait = 0;
      end
      i_axi_bresp = bresp_cfg;
      if (o_axi_bready) begin
        i_axi_bvalid = (b_wait >= b_delay);
        b_wait++;
      end else begin
        i_axi_bvalid = 1'b0;
        b_wait = 0;
      end
      i_axi_rdata = rdata_cfg;
      i_axi_rresp = rresp_cfg;
      if (o_axi_rready) begin
        i_axi_rvalid = (r_wait >= r_delay);
        r_wait++;
      end else begin
        i_axi_rvalid = 1'b0;
        r_wait = 0;
      end
    end
  end

  // Baselines for per-test monitor deltas.
  int b_aw, b_w, b_ar, b_awc, b_wc, b_arc, b_done;

  task automatic snap();
    b_aw = aw_hs; b_w = w_hs; b_ar = ar_hs;
    b_awc = aw_cyc; b_wc = w_cyc; b_arc = ar_cyc;
    b_done = done_cnt;
  endtask

  // Issue one command from a falling edge; returns the falling edges until o_done is seen.
  // With noise set, extra read strobes to 0x3000 are pulsed while the master is busy.
  task automatic do_xfer(input string tag, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] strb, input logic [2:0] prot,
                         input logic noise, output int lat);
    int l;
    i_req = 1'b1; i_we = we; i_addr = addr; i_wdata = wdata; i_wstrb = strb; i_prot = prot;
    l = 0;
    while (l < 40) begin
      @(negedge clk);
      l++;
      i_req = noise && (l == 2 || l == 3);
      if (noise && l == 2) begin
        i_we = 1'b0;
        i_addr = 32'h0000_3000;
      end
      if (o_done) break;
    end
    i_req = 1'b0;
    check_val({tag, "_done"}, o_done, 1);
    lat = l;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1);
  end

  initial begin
    int lat;
    resetn = 1'b0;
    i_req = 1'b0; i_we = 1'b0; i_addr = '0; i_wdata = '0; i_wstrb = '0; i_prot = '0;
    #3;
    check_val("rst_busy", o_busy, 0);
    check_val("rst_done", o_done, 0);
    check_val("rst_valids", {o_axi_awvalid, o_axi_wvalid, o_axi_arvalid}, 0);
    check_val("rst_readies", {o_axi_bready, o_axi_rready}, 0);
    check_val("rst_rdata", o_rdata, 0);
    check_val("rst_resp", o_resp, 0);
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);

    // Zero-wait write.
    snap();
    do_xfer("wr0", 1'b1, 32'h0000_1000, 32'hDEAD_BEEF, 4'hF, 3'b010, 1'b0, lat);
    check_val("wr0_lat", lat, 3);
    check_val("wr0_resp", o_resp, 2'b00);
    check_val("wr0_awcyc", aw_cyc - b_awc, 1);
    check_val("wr0_wcyc", w_cyc - b_wc, 1);
    check_val("wr0_awaddr", cap_awaddr, 32'h0000_1000);
    check_val("wr0_awprot", cap_awprot, 3'b010);
    check_val("wr0_wdata", cap_wdata, 32'hDEAD_BEEF);
    check_val("wr0_wstrb", cap_wstrb, 4'hF);
    check_val("wr0_donecnt", done_cnt - b_done, 1);
    @(negedge clk);
    check_val("wr0_done_pulse", o_done, 0);
    check_val("wr0_idle", o_busy, 0);

    // Write with AW ready delayed by 3 cycles, W immediate.
    aw_delay = 3; bresp_cfg = 2'b01;
    snap();
    do_xfer("wr1", 1'b1, 32'h0000_1010, 32'h0102_0304, 4'h3, 3'b000, 1'b0, lat);
    check_val("wr1_lat", lat, 6);
    check_val("wr1_awcyc", aw_cyc - b_awc, 4);
    check_val("wr1_wcyc", w_cyc - b_wc, 1);
    check_val("wr1_awhs", aw_hs - b_aw, 1);
    check_val("wr1_whs", w_hs - b_w, 1);
    check_val("wr1_order", order_err, 0);
    check_val("wr1_resp", o_resp, 2'b01);
    check_val("wr1_rdata_held", o_rdata, 0);
    aw_delay = 0;
    @(negedge clk);

    // Read with R valid delayed by 2 cycles.
    r_delay = 2; rresp_cfg = 2'b10; rdata_cfg = 32'hCAFE_1234;
    snap();
    do_xfer("rd0", 1'b0, 32'h0000_2000, 32'h0, 4'h0, 3'b001, 1'b0, lat);
    check_val("rd0_lat", lat, 5);
    check_val("rd0_rdata", o_rdata, 32'hCAFE_1234);
    check_val("rd0_resp", o_resp, 2'b10);
    check_val("rd0_araddr", cap_araddr, 32'h0000_2000);
    check_val("rd0_arprot", cap_arprot, 3'b001);
    check_val("rd0_arcyc", ar_cyc - b_arc, 1);
    check_val("rd0_order", order_err, 0);
    @(negedge clk);
    check_val("rd0_donecnt", done_cnt - b_done, 1);
    r_delay = 0;

    // Requests while busy are ignored.
    aw_delay = 3; bresp_cfg = 2'b11;
    snap();
    do_xfer("bsy", 1'b1, 32'h0000_1004, 32'h1234_5678, 4'hF, 3'b000, 1'b1, lat);
    check_val("bsy_lat", lat, 6);
    repeat (8) @(negedge clk);
    #1;
    check_val("bsy_awhs", aw_hs - b_aw, 1);
    check_val("bsy_arhs", ar_hs - b_ar, 0);
    check_val("bsy_awaddr", cap_awaddr, 32'h0000_1004);
    check_val("bsy_donecnt", done_cnt - b_done, 1);
    check_val("bsy_idle", o_busy, 0);
    check_val("bsy_resp", o_resp, 2'b11);
    aw_delay = 0;
    @(negedge clk);

    // Reset while waiting in the B phase.
    b_delay = 10;
    snap();
    i_req = 1'b1; i_we = 1'b1; i_addr = 32'h0000_1008; i_wdata = 32'h5555_AAAA;
    i_wstrb = 4'hF; i_prot = 3'b111;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      i_req = 1'b0;
      if (o_axi_bready) break;
    end
    check_val("rstb_in_wrb", o_axi_bready, 1);
    #2 resetn = 1'b0;
    #1;
    check_val("rstb_busy", o_busy, 0);
    check_val("rstb_done", o_done, 0);
    check_val("rstb_valids", {o_axi_awvalid, o_axi_wvalid, o_axi_arvalid}, 0);
    check_val("rstb_readies", {o_axi_bready, o_axi_rready}, 0);
    check_val("rstb_rdata", o_rdata, 0);
    check_val("rstb_resp", o_resp, 0);
    check_val("rstb_payload", {o_axi_awaddr, o_axi_wdata}, 0);
    check_val("rstb_prot_strb", {o_axi_awprot, o_axi_wstrb}, 0);
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    b_delay = 0;
    bresp_cfg = 2'b00;
    repeat (4) @(negedge clk);
    #1;
    check_val("rstb_nodone", done_cnt - b_done, 0);
    check_val("rstb_idle", o_busy, 0);
    @(negedge clk);
    snap();
    do_xfer("wr4", 1'b1, 32'h0000_4000, 32'hA5A5_5A5A, 4'hF, 3'b000, 1'b0, lat);
    check_val("wr4_lat", lat, 3);
    check_val("wr4_awaddr", cap_awaddr, 32'h0000_4000);
    check_val("wr4_wdata", cap_wdata, 32'hA5A5_5A5A);
    check_val("wr4_resp", o_resp, 2'b00);
    @(negedge clk);

    // Back-to-back reads: second request issued in the o_done cycle of the first.
    rresp_cfg = 2'b00; rdata_cfg = 32'h0BAD_F00D;
    snap();
    do_xfer("b2b0", 1'b0, 32'h0000_5000, 32'h0, 4'h0, 3'b000, 1'b0, lat);
    check_val("b2b0_lat", lat, 3);
    check_val("b2b0_rdata", o_rdata, 32'h0BAD_F00D);
    rdata_cfg = 32'h1357_9BDF; rresp_cfg = 2'b01;
    do_xfer("b2b1", 1'b0, 32'h0000_6000, 32'h0, 4'h0, 3'b000, 1'b0, lat);
    check_val("b2b1_lat", lat, 3);
    check_val("b2b1_rdata", o_rdata, 32'h1357_9BDF);
    check_val("b2b1_resp", o_resp, 2'b01);
    check_val("b2b1_araddr", cap_araddr, 32'h0000_6000);
    check_val("b2b_arhs", ar_hs - b_ar, 2);
    @(negedge clk);
    check_val("final_order", order_err, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/axi_lite_master_interface.md
AXI_LITE_MASTER_INTERFACE -- requirements
Module: axi_lite_master_interface

Interface
REQ-001 SHALL: ADDR_WIDTH, default 32, address width.
REQ-002 SHALL: DATA_WIDTH, default 32, data width.
REQ-003 SHALL: TRANS_W_STRB_W, default 4, write-strobe width (DATA_WIDTH/8).
REQ-004 SHALL: TRANS_WR_RESP_W, default 2, response width.
REQ-005 SHALL: TRANS_PROT, default 3, protection width.
REQ-006 SHALL: clk_i  in  1  sole clock; all logic on rising edge.
REQ-007 SHALL: resetn_i  in  1  reset, asynchronous, active-low.
REQ-008 SHALL: i_req  in  1  user command strobe, sampled only in IDLE.
REQ-009 SHALL: i_we  in  1  1 = write, 0 = read.
REQ-010 SHALL: i_addr  in  ADDR_WIDTH  command address.
REQ-011 SHALL: i_wdata  in  DATA_WIDTH  write data.
REQ-012 SHALL: i_wstrb  in  TRANS_W_STRB_W  write byte enables.
REQ-013 SHALL: i_prot  in  TRANS_PROT  AxPROT for command.
REQ-014 SHALL: o_busy  out  1  high whenever state != IDLE.
REQ-015 SHALL: o_done  out  1  one-cycle pulse at transaction completion.
REQ-016 SHALL: o_rdata  out  DATA_WIDTH  last read data, held.
REQ-017 SHALL: o_resp  out  TRANS_WR_RESP_W  last BRESP/RRESP, held.
REQ-018 SHALL: o_axi_awaddr  out  ADDR_WIDTH  write address.
REQ-019 SHALL: o_axi_awprot  out  TRANS_PROT  write protection.
REQ-020 SHALL: o_axi_awvalid  out  1  AW valid.
REQ-021 SHALL: i_axi_awready  in  1  AW ready.
REQ-022 SHALL: o_axi_wdata  out  DATA_WIDTH  write data.
REQ-023 SHALL: o_axi_wstrb  out  TRANS_W_STRB_W  write strobe.
REQ-024 SHALL: o_axi_wvalid  out  1  W valid.
REQ-025 SHALL: i_axi_wready  in  1  W ready.
REQ-026 SHALL: i_axi_bresp  in  TRANS_WR_RESP_W  write response.
REQ-027 SHALL: i_axi_bvalid  in  1  B valid.
REQ-028 SHALL: o_axi_bready  out  1  B ready.
REQ-029 SHALL: o_axi_araddr  out  ADDR_WIDTH  read address.
REQ-030 SHALL: o_axi_arprot  out  TRANS_PROT  read protection.
REQ-031 SHALL: o_axi_arvalid  out  1  AR valid.
REQ-032 SHALL: i_axi_arready  in  1  AR ready.
REQ-033 SHALL: i_axi_rdata  in  DATA_WIDTH  read data.
REQ-034 SHALL: i_axi_rresp  in  TRANS_WR_RESP_W  read response.
REQ-035 SHALL: i_axi_rvalid  in  1  R valid.
REQ-036 SHALL: o_axi_rready  out  1  R ready.

Function
REQ-037 SHALL: FSM states IDLE, WR_AW_W, WR_B, RD_AR, RD_R; one outstanding transaction; i_req outside IDLE ignored, no queuing.
REQ-038 SHALL: IDLE with i_req=1 registers addr/wdata/wstrb/prot; next cycle i_we=1 -> WR_AW_W (awvalid=wvalid=1), i_we=0 -> RD_AR (arvalid=1); AXI payload outputs stable while corresponding valid high.
REQ-039 SHALL: WR_AW_W: awvalid drops the cycle after awvalid&awready, wvalid after wvalid&wready, independently; -> WR_B once both handshakes done, incl. same-cycle completion; valid never drops before its handshake.
REQ-040 SHALL: WR_B: bready=1; on bvalid: o_resp<=bresp, o_done=1 next cycle, -> IDLE; o_rdata unchanged.
REQ-041 SHALL: RD_AR: arvalid held until arready -> RD_R; RD_R: rready=1; on rvalid: o_rdata<=rdata, o_resp<=rresp, o_done=1 next cycle, -> IDLE.
REQ-042 SHALL: minimum latency i_req -> o_done: write 3 cycles, read 3 cycles, with zero-wait slave; i_req in o_done cycle accepted.
REQ-043 SHALL: bready/rready asserted only in WR_B/RD_R; no combinational path from AXI inputs to AXI valid outputs.

Reset
REQ-044 SHALL: resetn_i=0 (asynchronous, any state, incl. mid-transaction) -> IDLE; all valids/readies, o_busy, o_done 0; o_rdata, o_resp, payload registers 0; aborted transaction produces no o_done.

Verification
REQ-045 SHALL: write 0x0000_1000, 0xDEAD_BEEF, strb 0xF, zero-wait slave, bresp 00 -> AW/W each 1 cycle, o_done after 3 cycles, o_resp=00.
REQ-046 SHALL: write with awready delayed 3 cycles, wready immediate -> wvalid 1 cycle, awvalid 4 cycles, bready only after both handshakes.
REQ-047 SHALL: read 0x0000_2000, rvalid delayed 2 cycles, rdata 0xCAFE_1234, rresp 10 -> o_rdata=0xCAFE_1234, o_resp=10, one o_done pulse.
REQ-048 SHALL: i_req pulses while o_busy=1 -> ignored; only first transaction appears on AXI.
REQ-049 SHALL: resetn_i low during WR_B -> all outputs 0 immediately, no o_done; following write 0x0000_4000 completes normally.
